// File: rtl/inst_fetch_pkg.sv
// Shared constants for the instruction fetch unit: pipeline control encoding,
// FSM state encodings, reset defaults and the address alignment helper.
package inst_fetch_pkg;

  localparam int CTRL_WIRE_W = 2;
  localparam logic [CTRL_WIRE_W-1:0] CTRL_STATE_RUN     = 2'b00;
  localparam logic [CTRL_WIRE_W-1:0] CTRL_STATE_STALLED = 2'b01;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
  localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;

  function automatic logic [63:0] word_align(input logic [63:0] addr);
    return {addr[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Output buffer toward the IF/ID register. A load takes priority over a clear;
// with neither command the held instruction, pc and valid flag are kept.
module fetch_buf
  import inst_fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] load_inst,
  input  logic [63:0] load_pc,
  output logic [31:0] inst,
  output logic [63:0] pc,
  output logic        valid
);

  logic [31:0] inst_r;
  logic [63:0] pc_r;
  logic        valid_r;

  // Buffer register: load, clear (back to NOP) or hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_r  <= NOP_INST;
      pc_r    <= RESET_PC;
      valid_r <= 1'b0;
    end else if (load) begin
      inst_r  <= load_inst;
      pc_r    <= load_pc;
      valid_r <= 1'b1;
    end else if (clear) begin
      inst_r  <= NOP_INST;
      pc_r    <= pc_r;
      valid_r <= 1'b0;
    end else begin
      inst_r  <= inst_r;
      pc_r    <= pc_r;
      valid_r <= valid_r;
    end
  end

  assign inst  = inst_r;
  assign pc    = pc_r;
  assign valid = valid_r;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: one outstanding memory request at a time, with
// redirects that either land immediately or are parked until the ack drains.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CTRL_WIRE_W-1:0] ctrl_signal_i,
  input  logic                   branch_en_i,
  input  logic [63:0]            branch_target_i,
  output logic                   imem_req_o,
  output logic [63:0]            imem_addr_o,
  input  logic                   imem_ack_i,
  input  logic [31:0]            imem_rdata_i,
  output logic [31:0]            if_inst_o,
  output logic [63:0]            pc_o,
  output logic                   if_valid_o
);

  logic [1:0]  state_r,      state_s;
  logic [63:0] fetch_pc_r,   fetch_pc_s;
  logic [63:0] pending_pc_r, pending_pc_s;
  logic [63:0] req_addr_r,   req_addr_s;
  logic        imem_req_r;
  logic        consume_s;
  logic        buf_load_s;
  logic        buf_clear_s;
  logic [63:0] branch_pc_s;

  assign consume_s   = if_valid_o && (ctrl_signal_i != CTRL_STATE_STALLED);
  assign branch_pc_s = word_align(branch_target_i);

  // Next-state and address bookkeeping for the fetch FSM
  always_comb begin
    state_s      = state_r;
    fetch_pc_s   = fetch_pc_r;
    pending_pc_s = pending_pc_r;
    req_addr_s   = req_addr_r;
    buf_load_s   = 1'b0;
    buf_clear_s  = branch_en_i || consume_s;
    case (state_r)
      ST_IDLE: begin
        if (branch_en_i) begin
          fetch_pc_s = branch_pc_s;
        end else if (!if_valid_o || consume_s) begin
          state_s    = ST_WAIT;
          req_addr_s = fetch_pc_r;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (imem_ack_i) begin
          state_s = ST_IDLE;
          if (branch_en_i) begin
            fetch_pc_s = branch_pc_s;
          end else begin
            buf_load_s = 1'b1;
            fetch_pc_s = fetch_pc_r + 64'd4;
          end
        end else if (branch_en_i) begin
          pending_pc_s = branch_pc_s;
          state_s      = ST_DRAIN;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        // A redirect arriving with the ack still wins over the parked one
        pending_pc_s = branch_en_i ? branch_pc_s : pending_pc_r;
        if (imem_ack_i) begin
          fetch_pc_s = pending_pc_s;
          state_s    = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM and address registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      fetch_pc_r   <= RESET_PC;
      pending_pc_r <= RESET_PC;
      req_addr_r   <= RESET_PC;
      imem_req_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      fetch_pc_r   <= fetch_pc_s;
      pending_pc_r <= pending_pc_s;
      req_addr_r   <= req_addr_s;
      imem_req_r   <= (state_s != ST_IDLE);
    end
  end

  assign imem_req_o  = imem_req_r;
  assign imem_addr_o = req_addr_r;

  fetch_buf #(
    .RESET_PC (RESET_PC),
    .NOP_INST (NOP_INST)
  ) u_fetch_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load_s),
    .clear     (buf_clear_s),
    .load_inst (imem_rdata_i),
    .load_pc   (req_addr_r),
    .inst      (if_inst_o),
    .pc        (pc_o),
    .valid     (if_valid_o)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: sequential fetch, stall hold, redirects in
// every state, reset mid-request and 64-bit pc wrap.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic                   clk;
  logic                   rst;
  logic [CTRL_WIRE_W-1:0] ctrl;
  logic                   branch_en;
  logic [63:0]            branch_target;
  logic                   imem_req;
  logic [63:0]            imem_addr;
  logic                   imem_ack;
  logic [31:0]            imem_rdata;
  logic [31:0]            if_inst;
  logic [63:0]            pc;
  logic                   if_valid;

  int checks   = 0;
  int failures = 0;

  inst_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .ctrl_signal_i   (ctrl),
    .branch_en_i     (branch_en),
    .branch_target_i (branch_target),
    .imem_req_o      (imem_req),
    .imem_addr_o     (imem_addr),
    .imem_ack_i      (imem_ack),
    .imem_rdata_i    (imem_rdata),
    .if_inst_o       (if_inst),
    .pc_o            (pc),
    .if_valid_o      (if_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; ctrl = CTRL_STATE_RUN; branch_en = 1'b0;
    branch_target = 64'd0; imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    step(); step();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%0b exp=0", imem_req); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", if_valid); end
    checks++; if (if_inst !== NOP) begin failures++; $display("FAIL rst_inst got=%h exp=%h", if_inst, NOP); end
    checks++; if (pc !== RPC) begin failures++; $display("FAIL rst_pc got=%h exp=%h", pc, RPC); end
    imem_ack = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_sequential();
    logic [63:0] exp_pc;
    for (int i = 0; i < 3; i++) begin
      exp_pc = RPC + 64'(i) * 64'd4;
      step();
      checks++; if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin failures++; $display("FAIL seq_req[%0d] got req=%0b addr=%h exp req=1 addr=%h", i, imem_req, imem_addr, exp_pc); end
      checks++; if (if_valid !== 1'b0 || if_inst !== NOP) begin failures++; $display("FAIL seq_idle[%0d] got valid=%0b inst=%h exp valid=0 inst=%h", i, if_valid, if_inst, NOP); end
      imem_ack = 1'b1; imem_rdata = 32'hA000_0000 + 32'(i);
      step();
      imem_ack = 1'b0;
      checks++; if (if_valid !== 1'b1 || pc !== exp_pc || if_inst !== 32'hA000_0000 + 32'(i)) begin failures++; $display("FAIL seq_load[%0d] got valid=%0b pc=%h inst=%h exp valid=1 pc=%h", i, if_valid, pc, if_inst, exp_pc); end
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL seq_req_drop[%0d] got=%0b exp=0", i, imem_req); end
    end
  endtask

  task automatic test_stall();
    ctrl = CTRL_STATE_STALLED;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (if_valid !== 1'b1 || pc !== 64'h8000_0008 || if_inst !== 32'hA000_0002) begin failures++; $display("FAIL stall_hold[%0d] got valid=%0b pc=%h inst=%h exp valid=1 pc=80000008 inst=a0000002", i, if_valid, pc, if_inst); end
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL stall_req[%0d] got=%0b exp=0", i, imem_req); end
    end
    ctrl = CTRL_STATE_RUN;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h8000_000C || if_valid !== 1'b0) begin failures++; $display("FAIL stall_release got req=%0b addr=%h valid=%0b exp req=1 addr=8000000c valid=0", imem_req, imem_addr, if_valid); end
  endtask

  task automatic test_branch_wait();
    branch_en = 1'b1; branch_target = 64'h8000_0102;
    step();
    branch_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h8000_000C) begin failures++; $display("FAIL drain_req[%0d] got req=%0b addr=%h exp req=1 addr=8000000c", i, imem_req, imem_addr); end
      if (i < 3) step();
    end
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    checks++; if (if_valid !== 1'b0 || if_inst !== NOP || imem_req !== 1'b0) begin failures++; $display("FAIL drain_discard got valid=%0b inst=%h req=%0b exp valid=0 inst=%h req=0", if_valid, if_inst, imem_req, NOP); end
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h8000_0100) begin failures++; $display("FAIL drain_next got req=%0b addr=%h exp req=1 addr=80000100", imem_req, imem_addr); end
  endtask

  task automatic test_branch_ack();
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0001;
    branch_en = 1'b1; branch_target = 64'h1000;
    step();
    imem_ack = 1'b0; branch_en = 1'b0;
    checks++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL bra_ack got valid=%0b req=%0b exp valid=0 req=0", if_valid, imem_req); end
    step();
    checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h1000) begin failures++; $display("FAIL bra_ack_next got valid=%0b req=%0b addr=%h exp valid=0 req=1 addr=1000", if_valid, imem_req, imem_addr); end
  endtask

  task automatic test_branch_drain();
    branch_en = 1'b1; branch_target = 64'h2000;
    step();
    branch_en = 1'b0;
    step();
    branch_en = 1'b1; branch_target = 64'h3000;
    step();
    branch_en = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h1000) begin failures++; $display("FAIL drain2_hold got req=%0b addr=%h exp req=1 addr=1000", imem_req, imem_addr); end
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h3000 || if_valid !== 1'b0) begin failures++; $display("FAIL drain2_next got req=%0b addr=%h valid=%0b exp req=1 addr=3000 valid=0", imem_req, imem_addr, if_valid); end
    branch_en = 1'b1; branch_target = 64'h4000;
    step();
    branch_en = 1'b1; branch_target = 64'h5006; imem_ack = 1'b1;
    step();
    branch_en = 1'b0; imem_ack = 1'b0;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h5004) begin failures++; $display("FAIL drain_ack_branch got req=%0b addr=%h exp req=1 addr=5004", imem_req, imem_addr); end
  endtask

  task automatic test_idle_ack_and_branch();
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    step();
    imem_ack = 1'b0;
    checks++; if (if_valid !== 1'b1 || pc !== 64'h5004 || if_inst !== 32'h1234_5678) begin failures++; $display("FAIL idle_load got valid=%0b pc=%h inst=%h exp valid=1 pc=5004 inst=12345678", if_valid, pc, if_inst); end
    ctrl = CTRL_STATE_STALLED; imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    step();
    imem_ack = 1'b0;
    checks++; if (if_valid !== 1'b1 || if_inst !== 32'h1234_5678 || imem_req !== 1'b0) begin failures++; $display("FAIL idle_ack_ignored got valid=%0b inst=%h req=%0b exp valid=1 inst=12345678 req=0", if_valid, if_inst, imem_req); end
    branch_en = 1'b1; branch_target = 64'h6001;
    step();
    branch_en = 1'b0;
    checks++; if (if_valid !== 1'b0 || if_inst !== NOP || imem_req !== 1'b0) begin failures++; $display("FAIL idle_branch_stall got valid=%0b inst=%h req=%0b exp valid=0 inst=%h req=0", if_valid, if_inst, imem_req, NOP); end
    ctrl = CTRL_STATE_RUN;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h6000) begin failures++; $display("FAIL idle_branch_next got req=%0b addr=%h exp req=1 addr=6000", imem_req, imem_addr); end
  endtask

  task automatic test_reset_mid();
    #3;
    rst = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_ctl got req=%0b valid=%0b exp req=0 valid=0", imem_req, if_valid); end
    checks++; if (if_inst !== NOP || pc !== RPC) begin failures++; $display("FAIL mid_rst_data got inst=%h pc=%h exp inst=%h pc=%h", if_inst, pc, NOP, RPC); end
    step(); step();
    rst = 1'b1;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== RPC) begin failures++; $display("FAIL mid_rst_first got req=%0b addr=%h exp req=1 addr=%h", imem_req, imem_addr, RPC); end
  endtask

  task automatic test_wrap();
    branch_en = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    branch_en = 1'b0; imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin failures++; $display("FAIL wrap_req got req=%0b addr=%h exp req=1 addr=fffffffffffffffc", imem_req, imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'h0000_0093;
    step();
    imem_ack = 1'b0;
    checks++; if (if_valid !== 1'b1 || pc !== 64'hFFFF_FFFF_FFFF_FFFC || if_inst !== 32'h0000_0093) begin failures++; $display("FAIL wrap_load got valid=%0b pc=%h inst=%h exp valid=1 pc=fffffffffffffffc inst=00000093", if_valid, pc, if_inst); end
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'd0) begin failures++; $display("FAIL wrap_next got req=%0b addr=%h exp req=1 addr=0", imem_req, imem_addr); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch_wait();
    test_branch_ack();
    test_branch_drain();
    test_idle_ack_and_branch();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, 64'h0000_0000_8000_0000, address of the first fetch after reset.
REQ-002 Parameter NOP_INST, 32'h0000_0013, instruction driven on if_inst_o while no valid instruction is held.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 ctrl_signal_i  input  `CTRL_Wire_Bus  pipeline control; `CTRL_STATE_Stalled means downstream does not consume this cycle.
REQ-006 branch_en_i  input  1  redirect request, one-cycle pulse.
REQ-007 branch_target_i  input  64  redirect address.
REQ-008 imem_req_o  output  1  instruction memory request.
REQ-009 imem_addr_o  output  64  request address, word aligned.
REQ-010 imem_ack_i  input  1  memory response valid for the current request.
REQ-011 imem_rdata_i  input  32  instruction word, valid with imem_ack_i.
REQ-012 if_inst_o  output  32  fetched instruction toward the IF/ID register.
REQ-013 pc_o  output  64  address of if_inst_o.
REQ-014 if_valid_o  output  1  if_inst_o/pc_o hold an unconsumed instruction.

Function
REQ-015 FSM states IDLE, WAIT, DRAIN; single outstanding memory request at most.
REQ-016 Consume condition: if_valid_o=1 and ctrl_signal_i != `CTRL_STATE_Stalled.
REQ-017 IDLE: if branch_en_i=0 and (if_valid_o=0 or consume), go WAIT, latching fetch_pc as the request address.
REQ-018 imem_req_o=1 exactly in WAIT and DRAIN; imem_addr_o stays constant from the first request cycle until the ack cycle.
REQ-019 WAIT, imem_ack_i=1, branch_en_i=0: if_inst_o<=imem_rdata_i, pc_o<=request address, if_valid_o<=1, fetch_pc<=fetch_pc+4 (64-bit wrap), go IDLE.
REQ-020 WAIT, imem_ack_i=0: hold state; ack may arrive in the first WAIT cycle (minimum 2 cycles per instruction).
REQ-021 Buffer held (if_valid_o=1, outputs unchanged) while stalled; a consume clears if_valid_o unless a new ack loads it in the same cycle.
REQ-022 Branch in IDLE: fetch_pc<=target with bits[1:0] forced to 0, if_valid_o<=0, stay IDLE.
REQ-023 Branch in WAIT with ack the same cycle: ack data discarded, fetch_pc<=aligned target, go IDLE.
REQ-024 Branch in WAIT without ack: pending_pc<=aligned target, go DRAIN; request continues unchanged.
REQ-025 DRAIN: on ack, data discarded, fetch_pc<=pending_pc, go IDLE; a further branch in DRAIN overwrites pending_pc (last wins), including in the ack cycle.
REQ-026 Any branch clears if_valid_o at the next edge regardless of stall.
REQ-027 if_inst_o=NOP_INST whenever if_valid_o=0.
REQ-028 imem_ack_i in IDLE is ignored.

Reset
REQ-029 rst=0 asynchronously forces state=IDLE, fetch_pc=RESET_PC, pending_pc=RESET_PC, pc_o=RESET_PC, if_valid_o=0, if_inst_o=NOP_INST, imem_req_o=0.
REQ-030 Reset mid-request abandons it; first request after release is at RESET_PC, and the memory shall tolerate the abandoned request.

Structure
REQ-031 FSM state encodings and NOP_INST value belong in defines.v; `CTRL_STATE_Stalled and `CTRL_Wire_Bus come from there unchanged.
REQ-032 The output buffer (if_inst_o/pc_o/if_valid_o) is a sub-module fetch_buf with load, clear and hold controls.

Verification
REQ-033 Reset release, ack in the first WAIT cycle every time, no stall -> pc_o 0x80000000, 0x80000004, 0x80000008 with if_valid_o pulses every 2 cycles.
REQ-034 Ack for 0x80000000, stall for 3 cycles -> if_valid_o=1 and pc_o held 3 cycles, no new imem_req_o until the stall drops.
REQ-035 Branch to 0x80000102 while in WAIT, ack 4 cycles later -> data discarded, next request address 0x80000100.
REQ-036 Branch to 0x1000 in the same cycle as the ack -> no if_valid_o for that data, next request 0x1000.
REQ-037 Branches to 0x2000 and then 0x3000 during DRAIN -> next request 0x3000.
REQ-038 rst=0 asserted during WAIT -> all outputs at reset values immediately; first request after release at 0x80000000.
